// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   hazard_state_t : memory-handshake tracker states
//   stage_ctrl_t   : load/flush pair consumed by a pipeline register
//   load_use()     : ID/EX load-use hazard detection
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_BOTH,
    WAIT_I,
    WAIT_D
  } hazard_state_t;

  typedef struct packed {
    logic load;
    logic flush;
  } stage_ctrl_t;

  // A load in EX writing a non-x0 register read by the ID instruction.
  function automatic logic load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2,
    input logic [4:0] ex_rd,
    input logic       ex_mem_read
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_tracker.sv
// Tracks instruction/data memory handshakes for the pipeline.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_imem_read, i_imem_resp : fetch request and completion pulse
//   i_dmem_access, i_dmem_resp : MEM-stage request and completion pulse
//   o_go                     : both memories satisfied, pipeline may advance
//   o_imem_read_en, o_dmem_access_en : requests gated so each issues once
module hazard_mem_tracker
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_imem_read,
  input  logic i_imem_resp,
  input  logic i_dmem_access,
  input  logic i_dmem_resp,
  output logic o_go,
  output logic o_imem_read_en,
  output logic o_dmem_access_en
);

  hazard_state_t r_state;
  hazard_state_t w_state_nxt;
  logic          w_i_done;
  logic          w_d_done;
  logic          w_go;

  // The state encodes the sticky flags: both responses present in the same
  // frozen cycle would have produced go, so {i_done,d_done}=11 cannot occur.
  assign w_i_done = (r_state == WAIT_D);
  assign w_d_done = (r_state == WAIT_I);

  assign w_go = (!i_imem_read   || i_imem_resp || w_i_done) &&
                (!i_dmem_access || i_dmem_resp || w_d_done);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // A response only sets its flag while its request is active, so a stray
  // pulse (e.g. late after reset) cannot block the next request.
  always_comb begin
    w_state_nxt = r_state;
    if (w_go) begin
      w_state_nxt = RUN;
    end else begin
      unique case (r_state)
        RUN, WAIT_BOTH: begin
          if (i_imem_read && i_imem_resp)        w_state_nxt = WAIT_D;
          else if (i_dmem_access && i_dmem_resp) w_state_nxt = WAIT_I;
          else                                   w_state_nxt = WAIT_BOTH;
        end
        WAIT_I:  w_state_nxt = WAIT_I;
        WAIT_D:  w_state_nxt = WAIT_D;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign o_go             = w_go && !i_rst;
  assign o_imem_read_en   = !i_rst && i_imem_read   && !w_i_done;
  assign o_dmem_access_en = !i_rst && i_dmem_access && !w_d_done;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   id_*, ex_*          : operand/destination info for load-use detection
//   ex_br_taken         : EX redirects the PC
//   imem_*/dmem_*       : memory requests and completion pulses
//   imem_read_en, dmem_access_en : gated memory requests
//   *_load, *_flush     : pipeline register enables
//   stall_cnt, flush_cnt : saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_access,
  input  logic             dmem_resp,
  output logic             imem_read_en,
  output logic             dmem_access_en,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             w_go;
  logic             w_lu;
  logic             w_br;
  logic             w_pc_load;
  logic             w_ex_mem_load;
  logic             w_mem_wb_load;
  stage_ctrl_t      w_if_id;
  stage_ctrl_t      w_id_ex;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  hazard_mem_tracker u_mem_tracker (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_imem_read      (imem_read),
    .i_imem_resp      (imem_resp),
    .i_dmem_access    (dmem_access),
    .i_dmem_resp      (dmem_resp),
    .o_go             (w_go),
    .o_imem_read_en   (imem_read_en),
    .o_dmem_access_en (dmem_access_en)
  );

  assign w_lu = load_use(id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read);
  assign w_br = ex_br_taken;

  // Branch outranks load-use: the ID instruction is on the wrong path anyway.
  always_comb begin
    w_pc_load     = 1'b0;
    w_ex_mem_load = 1'b0;
    w_mem_wb_load = 1'b0;
    w_if_id       = '0;
    w_id_ex       = '0;
    if (w_go) begin
      w_ex_mem_load = 1'b1;
      w_mem_wb_load = 1'b1;
      w_id_ex.load  = 1'b1;
      if (w_br) begin
        w_pc_load     = 1'b1;
        w_if_id       = '{load: 1'b1, flush: 1'b1};
        w_id_ex.flush = 1'b1;
      end else if (w_lu) begin
        w_id_ex.flush = 1'b1;
      end else begin
        w_pc_load    = 1'b1;
        w_if_id.load = 1'b1;
      end
    end
  end

  assign pc_load     = w_pc_load;
  assign if_id_load  = w_if_id.load;
  assign if_id_flush = w_if_id.flush;
  assign id_ex_load  = w_id_ex.load;
  assign id_ex_flush = w_id_ex.flush;
  assign ex_mem_load = w_ex_mem_load;
  assign mem_wb_load = w_mem_wb_load;

  assign w_stall_inc = !w_go || (w_lu && !w_br);
  assign w_flush_inc = w_go && w_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
  logic        imem_read, imem_resp, dmem_access, dmem_resp;

  logic        imem_read_en, dmem_access_en;
  logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        if_id_flush, id_ex_flush;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_imem_read_en, s_dmem_access_en;
  logic        s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load;
  logic        s_if_id_flush, s_id_ex_flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       tag;
    logic [4:0]  ld;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0]  fl;   // {if_id_flush, id_ex_flush}
    logic [1:0]  en;   // {imem_read_en, dmem_access_en}
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_access(dmem_access), .dmem_resp(dmem_resp),
    .imem_read_en(imem_read_en), .dmem_access_en(dmem_access_en),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy driven identically, to exercise saturation.
  pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_access(dmem_access), .dmem_resp(dmem_resp),
    .imem_read_en(s_imem_read_en), .dmem_access_en(s_dmem_access_en),
    .pc_load(s_pc_load), .if_id_load(s_if_id_load), .id_ex_load(s_id_ex_load),
    .ex_mem_load(s_ex_mem_load), .mem_wb_load(s_mem_wb_load),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic ir, input logic iresp, input logic da, input logic dresp);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_br_taken = br;
    imem_read = ir; imem_resp = iresp; dmem_access = da; dmem_resp = dresp;
  endtask

  function automatic int unsigned sat3(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  // Push the expectation for the cycle just driven, then compare at negedge.
  task automatic cyc(input string tag, input logic [4:0] ld, input logic [1:0] fl,
                     input logic [1:0] en, input int unsigned sc, input int unsigned fc);
    exp_t e;
    logic [8:0]  obs_ctl;
    logic [63:0] obs_cnt;
    logic [3:0]  obs_sat;
    sb.push_back('{tag, ld, fl, en, sc, fc});
    @(negedge clk);
    e = sb.pop_front();
    obs_ctl = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, imem_read_en, dmem_access_en};
    obs_cnt = {stall_cnt, flush_cnt};
    obs_sat = {s_stall_cnt, s_flush_cnt};
    n_cmp++;
    assert (obs_ctl === {e.ld, e.fl, e.en}) else begin
      n_err++;
      $error("FAIL %s ctl: got %b want %b", e.tag, obs_ctl, {e.ld, e.fl, e.en});
    end
    n_cmp++;
    assert (obs_cnt === {e.sc[31:0], e.fc[31:0]}) else begin
      n_err++;
      $error("FAIL %s cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
             e.tag, stall_cnt, flush_cnt, e.sc, e.fc);
    end
    n_cmp++;
    assert (obs_sat === {2'(sat3(e.sc)), 2'(sat3(e.fc))}) else begin
      n_err++;
      $error("FAIL %s satcnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
             e.tag, s_stall_cnt, s_flush_cnt, sat3(e.sc), sat3(e.fc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    cyc("reset", 5'b00000, 2'b00, 2'b00, 0, 0);
    rst = 1'b0;

    // Free-running fetch, no hazard
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("idle", 5'b11111, 2'b00, 2'b10, 0, 0);
    // Load-use on rs1
    drive(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("lu_rs1", 5'b00111, 2'b01, 2'b10, 0, 0);
    // Load-use on rs2 only
    drive(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("lu_rs2", 5'b00111, 2'b01, 2'b10, 1, 0);
    // rs1 matches but is not read
    drive(5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("lu_unused", 5'b11111, 2'b00, 2'b10, 2, 0);
    // x0 destination never hazards
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("x0", 5'b11111, 2'b00, 2'b10, 2, 0);
    // Branch together with load-use: branch wins
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("br_lu", 5'b11111, 2'b11, 2'b10, 2, 0);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("after_br", 5'b11111, 2'b00, 2'b10, 2, 1);

    // Split handshake: imem resp at cycle 2, dmem resp at cycle 5
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("split_c1", 5'b00000, 2'b00, 2'b11, 2, 1);
    imem_resp = 1'b1;
    cyc("split_c2", 5'b00000, 2'b00, 2'b11, 3, 1);
    imem_resp = 1'b0;
    cyc("split_c3", 5'b00000, 2'b00, 2'b01, 4, 1);
    cyc("split_c4", 5'b00000, 2'b00, 2'b01, 5, 1);
    dmem_resp = 1'b1;
    cyc("split_c5", 5'b11111, 2'b00, 2'b01, 6, 1);
    imem_resp = 1'b1;
    cyc("split_run", 5'b11111, 2'b00, 2'b11, 6, 1);

    // Branch held while dmem is pending
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("brwait_1", 5'b00000, 2'b00, 2'b01, 6, 1);
    cyc("brwait_2", 5'b00000, 2'b00, 2'b01, 7, 1);
    cyc("brwait_3", 5'b00000, 2'b00, 2'b01, 8, 1);
    dmem_resp = 1'b1;
    cyc("brwait_resp", 5'b11111, 2'b11, 2'b01, 9, 1);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("brwait_done", 5'b11111, 2'b00, 2'b00, 9, 2);

    // Reset while waiting on dmem with i_done set
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("wd_enter", 5'b00000, 2'b00, 2'b11, 9, 2);
    imem_resp = 1'b0;
    cyc("wd_hold", 5'b00000, 2'b00, 2'b01, 10, 2);
    rst = 1'b1;
    cyc("wd_rst", 5'b00000, 2'b00, 2'b00, 11, 2);
    rst = 1'b0;
    cyc("post_rst", 5'b00000, 2'b00, 2'b11, 0, 0);
    // Late imem_resp without an active request must not set i_done
    imem_read = 1'b0; imem_resp = 1'b1;
    cyc("late_resp", 5'b00000, 2'b00, 2'b01, 1, 0);
    imem_read = 1'b1; imem_resp = 1'b0;
    cyc("late_ignored", 5'b00000, 2'b00, 2'b11, 2, 0);
    imem_resp = 1'b1; dmem_resp = 1'b1;
    cyc("late_done", 5'b11111, 2'b00, 2'b11, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
